// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex glyph table for the seven-segment scanner.
package seven_seg_pkg;

    // Register select on the single-bit address line
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CTRL = 1'b1;

    // CTRL register field positions
    localparam int DP_LSB    = 0;
    localparam int BLANK_LSB = 8;
    localparam int EN_BIT    = 16;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low seven-segment glyph.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nib);

endmodule

// File: rtl/seven_seg_scan.sv
// Bus-slave multiplexed hex display driver: DATA/CTRL registers behind a
// single-pulse STB/ACK handshake, a free-running digit scan, and a
// registered Segment/AN output stage.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 131072
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                STB,
    input  logic                WE,
    input  logic                ADR,
    input  logic [31:0]         DAT_I,
    output logic [31:0]         DAT_O,
    output logic                ACK,
    output logic [7:0]          Segment,
    output logic [N_DIGITS-1:0] AN
);

    localparam int DW = 4 * N_DIGITS;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DW-1:0]       data_q, data_d;
    logic [N_DIGITS-1:0] dp_q, dp_d;
    logic [N_DIGITS-1:0] blank_q, blank_d;
    logic                en_q, en_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_o_q, dat_o_d;
    logic [CW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic        xfer, wr, rd, wrap;
    logic [31:0] rd_val;
    logic [3:0]  cur_nib;
    logic        cur_dp, cur_blank;
    logic [6:0]  cur_glyph;
    logic [N_DIGITS-1:0] an_sel;

    // A transfer is taken only on the edge that raises ACK, so a held STB
    // alternates ACK and each transfer commits exactly once.
    assign xfer = STB & ~ack_q;
    assign wr   = xfer & WE;
    assign rd   = xfer & ~WE;

    // Read mux; unimplemented bits read back as zero
    always_comb begin
        rd_val = '0;
        if (ADR == ADR_DATA) begin
            rd_val[DW-1:0] = data_q;
        end else begin
            rd_val[DP_LSB +: N_DIGITS]    = dp_q;
            rd_val[BLANK_LSB +: N_DIGITS] = blank_q;
            rd_val[EN_BIT]                = en_q;
        end
    end

    // Bus handshake, register writes and read data capture
    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        en_d    = en_q;
        ack_d   = xfer;
        dat_o_d = rd ? rd_val : dat_o_q;
        if (wr) begin
            if (ADR == ADR_DATA) begin
                data_d = DAT_I[DW-1:0];
            end else begin
                dp_d    = DAT_I[DP_LSB +: N_DIGITS];
                blank_d = DAT_I[BLANK_LSB +: N_DIGITS];
                en_d    = DAT_I[EN_BIT];
            end
        end
    end

    // Prescaler and digit index; idx wraps at N_DIGITS-1, never beyond
    always_comb begin
        wrap    = (presc_q == CW'(SCAN_DIV - 1));
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (wrap)
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Select the current digit's nibble and mask bits without indexing by idx
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = data_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_blank = blank_q[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    seven_seg_decoder u_dec (
        .nib   (cur_nib),
        .glyph (cur_glyph)
    );

    // Next value of the registered display outputs
    always_comb begin
        if (!en_q || cur_blank) begin
            seg_d = 8'hFF;
            an_d  = '1;
        end else begin
            seg_d = {~cur_dp, cur_glyph};
            an_d  = an_sel;
        end
    end

    // State update; reset darkens the display and drops any pending ACK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign ACK     = ack_q;
    assign DAT_O   = dat_o_q;
    assign Segment = seg_q;
    assign AN      = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench: a 4-digit scanner with a fast scan and a 3-digit one.
module tb_seven_seg_scan;

    logic        clk, rst;
    logic        stb, we, adr;
    logic [31:0] dat_i, dat_o;
    logic        ack;
    logic [7:0]  seg;
    logic [3:0]  an;

    logic        stb3, we3, adr3;
    logic [31:0] dat_i3, dat_o3;
    logic        ack3;
    logic [7:0]  seg3;
    logic [2:0]  an3;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rdv;

    seven_seg_scan #(.N_DIGITS(4), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .STB(stb), .WE(we), .ADR(adr), .DAT_I(dat_i),
        .DAT_O(dat_o), .ACK(ack), .Segment(seg), .AN(an)
    );

    seven_seg_scan #(.N_DIGITS(3), .SCAN_DIV(2)) u_dut3 (
        .clk(clk), .rst(rst), .STB(stb3), .WE(we3), .ADR(adr3), .DAT_I(dat_i3),
        .DAT_O(dat_o3), .ACK(ack3), .Segment(seg3), .AN(an3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer; waits a bounded number of cycles for ACK
    task automatic xfer(input bit u3, input bit w, input bit a, input logic [31:0] wd,
                        output logic [31:0] rd);
        int  n = 0;
        bit  got = 0;
        rd = '0;
        @(negedge clk);
        if (u3) begin stb3 = 1; we3 = w; adr3 = a; dat_i3 = wd; end
        else    begin stb  = 1; we  = w; adr  = a; dat_i  = wd; end
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if ((u3 ? ack3 : ack) === 1'b1) begin
                got = 1;
                rd  = u3 ? dat_o3 : dat_o;
            end
        end
        stb = 0;
        stb3 = 0;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wr(input bit u3, input bit a, input logic [31:0] wd);
        logic [31:0] dummy;
        xfer(u3, 1'b1, a, wd, dummy);
    endtask

    task automatic wait_an(input bit u3, input logic [3:0] exp, input string tag);
        int n = 0;
        bit found = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if ((u3 ? {1'b0, an3} : an) == exp) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic slot(input bit u3, input int cyc, input logic [3:0] exp_an,
                        input logic [7:0] exp_seg, input string tag);
        repeat (cyc) @(negedge clk);
        check({tag, "_an"},  u3 ? 32'(an3) : 32'(an), 32'(exp_an));
        check({tag, "_seg"}, u3 ? 32'(seg3) : 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        rst = 1; stb = 0; we = 0; adr = 0; dat_i = '0;
        stb3 = 0; we3 = 0; adr3 = 0; dat_i3 = '0;
        #2;
        check("rst_seg", 32'(seg), 32'h FF);
        check("rst_an",  32'(an), 32'h F);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dato", dat_o, 32'd0);
        @(negedge clk);
        rst = 0;

        // Register reads after reset
        xfer(0, 0, 0, '0, rdv); check("rd_data0", rdv, 32'h0);
        xfer(0, 0, 1, '0, rdv); check("rd_ctrl0", rdv, 32'h0);

        // STB held three cycles: ACK 1,0,1
        @(negedge clk);
        stb = 1; we = 1; adr = 0; dat_i = 32'h0000_12AF;
        @(negedge clk); check("held_ack0", 32'(ack), 32'd1);
        @(negedge clk); check("held_ack1", 32'(ack), 32'd0);
        @(negedge clk); check("held_ack2", 32'(ack), 32'd1);
        stb = 0;
        @(negedge clk); check("held_ack3", 32'(ack), 32'd0);
        xfer(0, 0, 0, '0, rdv); check("rd_data_12af", rdv, 32'h0000_12AF);

        // Unimplemented CTRL bits read zero
        wr(0, 1, 32'hFFFF_FFFF);
        xfer(0, 0, 1, '0, rdv); check("rd_ctrl_mask", rdv, 32'h0001_0F0F);

        // Scan with dp on digit 1
        wr(0, 1, 32'h0001_0002);
        wait_an(0, 4'hE, "scan_find_e");
        check("s0_seg_first", 32'(seg), 32'h8E);
        wait_an(0, 4'hD, "scan_find_d");
        check("s1_seg", 32'(seg), 32'h08);
        slot(0, 4, 4'hB, 8'hA4, "s2");
        slot(0, 4, 4'h7, 8'hF9, "s3");
        slot(0, 4, 4'hE, 8'h8E, "s0");
        slot(0, 4, 4'hD, 8'h08, "s1b");

        // Blank digit 2
        wr(0, 1, 32'h0001_0400);
        wait_an(0, 4'hE, "blk_find_e");
        wait_an(0, 4'hD, "blk_find_d");
        check("b1_seg", 32'(seg), 32'h88);
        slot(0, 4, 4'hF, 8'hFF, "b2");
        slot(0, 4, 4'h7, 8'hF9, "b3");
        slot(0, 4, 4'hE, 8'h8E, "b0");

        // Single-pulse write, applied once
        wr(0, 0, 32'h0000_3456);
        xfer(0, 0, 0, '0, rdv); check("rd_data_3456", rdv, 32'h0000_3456);

        // STB glitch between edges: no ACK, no write
        @(negedge clk);
        #1 stb = 1; we = 1; adr = 0; dat_i = 32'h0000_BEEF;
        #2 stb = 0;
        @(negedge clk); check("glitch_ack", 32'(ack), 32'd0);
        xfer(0, 0, 0, '0, rdv); check("glitch_data", rdv, 32'h0000_3456);

        // Re-raise STB the cycle after ACK starts a new transfer
        @(negedge clk);
        stb = 1; we = 1; adr = 0; dat_i = 32'h0000_789A;
        @(negedge clk); check("rr_ack_w", 32'(ack), 32'd1);
        stb = 0;
        @(negedge clk); check("rr_ack_gap", 32'(ack), 32'd0);
        stb = 1; we = 0;
        @(negedge clk); check("rr_ack_r", 32'(ack), 32'd1);
        check("rr_dato", dat_o, 32'h0000_789A);
        stb = 0;

        // Reset mid-cycle while an ACK is pending and display is lit
        @(negedge clk);
        stb = 1; we = 1; adr = 0; dat_i = 32'h0000_5555;
        @(posedge clk);
        #2;
        check("mr_ack_pre", 32'(ack), 32'd1);
        rst = 1;
        #1;
        check("mr_ack", 32'(ack), 32'd0);
        check("mr_seg", 32'(seg), 32'hFF);
        check("mr_an",  32'(an), 32'hF);
        stb = 0;
        @(negedge clk);
        rst = 0;
        xfer(0, 0, 0, '0, rdv); check("mr_data", rdv, 32'h0);
        xfer(0, 0, 1, '0, rdv); check("mr_ctrl", rdv, 32'h0);

        // Three digits, two-cycle slots
        wr(1, 1, 32'h0001_0000);
        wr(1, 0, 32'hFFFF_FFFF);
        xfer(1, 0, 0, '0, rdv); check("n3_rd_data", rdv, 32'h0000_0FFF);
        wait_an(1, 4'h6, "n3_find_6");
        wait_an(1, 4'h5, "n3_find_5");
        check("n3_s1_seg", 32'(seg3), 32'h8E);
        slot(1, 2, 4'h3, 8'h8E, "n3_s2");
        slot(1, 2, 4'h6, 8'h8E, "n3_s0");
        slot(1, 2, 4'h5, 8'h8E, "n3_s1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
